// File: rtl/tetris_input_pkg.sv
// -----------------------------------------------------------------------------
// tetris_input_pkg
// Shared constants for the Tetris joystick/button input path (register r27).
// Move codes match the values the game software decodes; button indices give
// the bit position of each raw JB line on the buttons bus.
// -----------------------------------------------------------------------------
package tetris_input_pkg;

    // Move codes presented to the CPU
    localparam logic [3:0] CODE_NONE  = 4'd0;
    localparam logic [3:0] CODE_UP    = 4'd1;
    localparam logic [3:0] CODE_RIGHT = 4'd2;
    localparam logic [3:0] CODE_DOWN  = 4'd3;
    localparam logic [3:0] CODE_LEFT  = 4'd4;
    localparam logic [3:0] CODE_SL    = 4'd7;
    localparam logic [3:0] CODE_SR    = 4'd8;
    localparam logic [3:0] CODE_HOLD  = 4'd9;

    // Bit positions on the buttons bus
    localparam int BTN_UP    = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_SL    = 4;
    localparam int BTN_SR    = 5;
    localparam int BTN_HOLD  = 6;
    localparam int BTN_RST   = 7;

    // Buttons 0..NUM_EVT-1 generate queued events; BTN_RST does not
    localparam int NUM_EVT = 7;

    // Map an event button index to its move code
    function automatic logic [3:0] btn_code(input int idx);
        logic [3:0] c;
        case (idx)
            BTN_UP:    c = CODE_UP;
            BTN_RIGHT: c = CODE_RIGHT;
            BTN_DOWN:  c = CODE_DOWN;
            BTN_LEFT:  c = CODE_LEFT;
            BTN_SL:    c = CODE_SL;
            BTN_SR:    c = CODE_SR;
            BTN_HOLD:  c = CODE_HOLD;
            default:   c = CODE_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tetris_debounce.sv
// -----------------------------------------------------------------------------
// tetris_debounce
// Single-bit 2-flop synchronizer followed by a stable-level debouncer. The
// output level only changes after the synchronized input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
//
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   raw_i    raw asynchronous button line
//   level_o  debounced level
// -----------------------------------------------------------------------------
module tetris_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            // The current cycle is the DEBOUNCE_CYCLES-th disagreeing one
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// -----------------------------------------------------------------------------
// tetris_input_ctrl
// Producer for the CPU joystick/button register r27. Debounces eight raw
// button lines, turns press edges (and optional auto-repeat of left/right/down)
// into pending events, and arbitrates one event per cycle into a small code
// FIFO that the CPU drains one entry per read.
//
// Build option: define TETRIS_INPUT_REPEAT_EN to enable auto-repeat on
// left/right/down. Without it REPEAT_DELAY/REPEAT_RATE are unused.
//
// Ports:
//   clock       system clock
//   reset       asynchronous active-low reset
//   buttons     raw lines: [0]up [1]right [2]down [3]left [4]SL [5]SR
//               [6]hold [7]game-reset
//   rd_en       pop one code (ignored while empty)
//   code        FIFO head, 0 when empty
//   valid       FIFO non-empty
//   overflow    sticky: a press merged into an already-pending event
//   game_reset  debounced level of buttons[7]
// -----------------------------------------------------------------------------
module tetris_input_ctrl
    import tetris_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_RATE     = 2500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] buttons,
    input  logic       rd_en,
    output logic [3:0] code,
    output logic       valid,
    output logic       overflow,
    output logic       game_reset
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]         lvl;
    logic [NUM_EVT-1:0] lvl_prev_q;
    logic [NUM_EVT-1:0] rise;
    logic [NUM_EVT-1:0] rep_fire;
    logic [NUM_EVT-1:0] pend_q, pend_d;
    logic [NUM_EVT-1:0] grant;
    logic               ovf_q, ovf_d;

    logic [3:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               full, pop, wr_en;
    logic [3:0]         wr_code;

    // Synchronize + debounce every line
    for (genvar g = 0; g < 8; g++) begin : g_db
        tetris_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i  (clock),
            .rst_ni (reset),
            .raw_i  (buttons[g]),
            .level_o(lvl[g])
        );
    end

    assign rise = lvl[NUM_EVT-1:0] & ~lvl_prev_q;

`ifdef TETRIS_INPUT_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);

    // One counter each for right, down, left (consecutive indices)
    logic [RW-1:0] rep_cnt_q [3];
    logic [RW-1:0] rep_cnt_d [3];
    logic [2:0]    rep_first_q, rep_first_d;

    // While released the counter idles at 0 with the "first" flag armed, so
    // cnt reaching REPEAT_DELAY lands exactly REPEAT_DELAY cycles after the
    // press event; later repeats restart from 0 and fire at REPEAT_RATE-1.
    always_comb begin
        rep_fire    = '0;
        rep_first_d = rep_first_q;
        for (int i = 0; i < 3; i++) begin
            rep_cnt_d[i] = rep_cnt_q[i];
            if (!lvl[BTN_RIGHT + i]) begin
                rep_cnt_d[i]   = '0;
                rep_first_d[i] = 1'b1;
            end else if (rep_first_q[i] && rep_cnt_q[i] == RW'(REPEAT_DELAY)) begin
                rep_fire[BTN_RIGHT + i] = 1'b1;
                rep_cnt_d[i]            = '0;
                rep_first_d[i]          = 1'b0;
            end else if (!rep_first_q[i] && rep_cnt_q[i] == RW'(REPEAT_RATE - 1)) begin
                rep_fire[BTN_RIGHT + i] = 1'b1;
                rep_cnt_d[i]            = '0;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_first_q <= '0;
            for (int i = 0; i < 3; i++) rep_cnt_q[i] <= '0;
        end else begin
            rep_first_q <= rep_first_d;
            for (int i = 0; i < 3; i++) rep_cnt_q[i] <= rep_cnt_d[i];
        end
    end
`else
    assign rep_fire = '0;
`endif

    // Arbiter: one write per cycle, highest index (hold) wins
    always_comb begin
        pop     = rd_en && (cnt_q != '0);
        full    = (cnt_q == CW'(FIFO_DEPTH));
        grant   = '0;
        wr_en   = 1'b0;
        wr_code = CODE_NONE;
        if (!full || pop) begin
            for (int i = 0; i < NUM_EVT; i++) begin
                if (pend_q[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    wr_en    = 1'b1;
                    wr_code  = btn_code(i);
                end
            end
        end
    end

    // Only a real press merging into an uncollected event is an overflow;
    // auto-repeats simply coalesce while the FIFO is backed up.
    always_comb begin
        pend_d = (pend_q & ~grant) | rise | rep_fire;
        ovf_d  = ovf_q | (|(rise & pend_q & ~grant));
    end

    always_comb begin
        wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop   ? rptr_q + 1'b1 : rptr_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lvl_prev_q <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            lvl_prev_q <= lvl[NUM_EVT-1:0];
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked while the count is zero
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wptr_q] <= wr_code;
    end

    assign valid      = (cnt_q != '0);
    assign code       = valid ? mem_q[rptr_q] : CODE_NONE;
    assign overflow   = ovf_q;
    assign game_reset = lvl[BTN_RST];

endmodule

// File: tb/tb_tetris_input_ctrl.sv
module tb_tetris_input_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] buttons;
    logic       rd_en;
    logic [3:0] code;
    logic       valid;
    logic       overflow;
    logic       game_reset;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tetris_input_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (5),
        .FIFO_DEPTH     (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .buttons   (buttons),
        .rd_en     (rd_en),
        .code      (code),
        .valid     (valid),
        .overflow  (overflow),
        .game_reset(game_reset)
    );

    typedef struct {
        logic [7:0] btn;
        logic       rd;
        int         ncyc;
        logic [3:0] code;
        logic       vld;
        logic       ovf;
        logic       grst;
    } vec_t;

    vec_t vecs[$];
    int   cap_edge[$];
    logic [3:0] cap_code[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] b, input logic r, input int n,
                       input logic [3:0] c, input logic v, input logic o, input logic g);
        vec_t t;
        t.btn = b; t.rd = r; t.ncyc = n; t.code = c; t.vld = v; t.ovf = o; t.grst = g;
        vecs.push_back(t);
    endtask

    task automatic chk_out(input string nm, input logic [3:0] c, input logic v,
                           input logic o, input logic g);
        chk({nm, ".code"}, code, c);
        chk({nm, ".valid"}, valid, v);
        chk({nm, ".overflow"}, overflow, o);
        chk({nm, ".game_reset"}, game_reset, g);
    endtask

    // Hold b for 38 raw cycles, popping every code as soon as it appears and
    // recording the cycle (counted from the press) at which it became visible.
    task automatic capture(input logic [7:0] b);
        cap_edge.delete();
        cap_code.delete();
        buttons = b;
        rd_en   = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clock);
            #1;
            if (valid) begin
                cap_edge.push_back(cyc);
                cap_code.push_back(code);
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
            buttons = (cyc < 38) ? b : 8'h00;
        end
        rd_en = 1'b0;
    endtask

    task automatic chk_capture(input string nm, input int exp_e[$], input logic [3:0] c);
        chk({nm, ".count"}, cap_edge.size(), exp_e.size());
        foreach (exp_e[i]) begin
            if (i < cap_edge.size()) begin
                chk($sformatf("%s.cycle%0d", nm, i), cap_edge[i], exp_e[i]);
                chk($sformatf("%s.code%0d", nm, i), cap_code[i], c);
            end
        end
    endtask

    initial begin
        int exp_down[$];
        int exp_sl[$];

        // glitch on left, then a real left press
        add(8'h08, 0, 5,  4'd0, 0, 0, 0);
        add(8'h00, 0, 12, 4'd0, 0, 0, 0);
        add(8'h08, 0, 11, 4'd0, 0, 0, 0);
        add(8'h08, 0, 1,  4'd4, 1, 0, 0);
        add(8'h08, 1, 1,  4'd0, 0, 0, 0);
        add(8'h00, 0, 12, 4'd0, 0, 0, 0);
        // game reset level only
        add(8'h80, 0, 9,  4'd0, 0, 0, 0);
        add(8'h80, 0, 1,  4'd0, 0, 0, 1);
        add(8'h00, 0, 10, 4'd0, 0, 0, 0);
        // up + left + hold together
        add(8'h49, 0, 12, 4'd9, 1, 0, 0);
        add(8'h49, 0, 1,  4'd9, 1, 0, 0);
        add(8'h49, 1, 1,  4'd4, 1, 0, 0);
        add(8'h49, 1, 1,  4'd1, 1, 0, 0);
        add(8'h49, 1, 1,  4'd0, 0, 0, 0);
        add(8'h00, 0, 12, 4'd0, 0, 0, 0);
        // six presses into a 4-deep FIFO
        add(8'h3F, 0, 12, 4'd8, 1, 0, 0);
        add(8'h00, 0, 12, 4'd8, 1, 0, 0);
        add(8'h00, 1, 1,  4'd7, 1, 0, 0);
        add(8'h00, 1, 1,  4'd4, 1, 0, 0);
        add(8'h00, 1, 1,  4'd3, 1, 0, 0);
        add(8'h00, 1, 1,  4'd2, 1, 0, 0);
        add(8'h00, 1, 1,  4'd1, 1, 0, 0);
        add(8'h00, 1, 1,  4'd0, 0, 0, 0);
        // fill FIFO, then double-press right while it is still pending
        add(8'h71, 0, 12, 4'd9, 1, 0, 0);
        add(8'h00, 0, 12, 4'd9, 1, 0, 0);
        add(8'h02, 0, 12, 4'd9, 1, 0, 0);
        add(8'h00, 0, 12, 4'd9, 1, 0, 0);
        add(8'h02, 0, 12, 4'd9, 1, 1, 0);
        add(8'h00, 0, 12, 4'd9, 1, 1, 0);
        add(8'h00, 1, 1,  4'd8, 1, 1, 0);
        add(8'h00, 1, 1,  4'd7, 1, 1, 0);
        add(8'h00, 1, 1,  4'd1, 1, 1, 0);
        add(8'h00, 1, 1,  4'd2, 1, 1, 0);
        add(8'h00, 1, 1,  4'd0, 0, 1, 0);

        // reset state
        reset   = 1'b0;
        buttons = 8'h00;
        rd_en   = 1'b0;
        #1;
        chk_out("reset", 4'd0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            buttons = vecs[i].btn;
            rd_en   = vecs[i].rd;
            repeat (vecs[i].ncyc) @(posedge clock);
            #1;
            chk_out($sformatf("v%0d", i), vecs[i].code, vecs[i].vld,
                    vecs[i].ovf, vecs[i].grst);
        end
        rd_en = 1'b0;

        // three entries queued, game reset held, then async reset mid-FIFO
        buttons = 8'hC9;
        repeat (14) @(posedge clock);
        #1;
        chk_out("prerst", 4'd9, 1, 1, 1);
        reset = 1'b0;
        #1;
        chk_out("midrst", 4'd0, 0, 0, 0);
        buttons = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        chk_out("postrst", 4'd0, 0, 0, 0);

        // held down: press event plus auto-repeats when enabled
`ifdef TETRIS_INPUT_REPEAT_EN
        exp_down = '{12, 32, 37, 42, 47};
`else
        exp_down = '{12};
`endif
        capture(8'h04);
        chk_capture("hold_down", exp_down, 4'd3);

        // held SL never repeats
        exp_sl = '{12};
        capture(8'h10);
        chk_capture("hold_sl", exp_sl, 4'd7);
        chk_out("final", 4'd0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tetris_input_ctrl.md
# tetris_input_ctrl

Input-side producer for the Tetris CPU's joystick/button register (r27). Synchronizes and debounces the eight raw JB button lines. Turns press edges, plus optional auto-repeat, into 4-bit move codes held in a small FIFO, which the CPU drains one code per read. It replaces the combinational priority mux in the top level, so simultaneous presses are queued in priority order rather than lost.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz).
- REPEAT_DELAY, 15000000: held cycles before the first auto-repeat (300 ms).
- REPEAT_RATE, 2500000: cycles between subsequent auto-repeats (50 ms).
- FIFO_DEPTH, 4: code FIFO entries; power of two, ≥2.

Ports:
- clock  in  1  system clock (50 MHz CPU clock).
- reset  in  1  asynchronous, active-low reset.
- buttons  in  8  raw asynchronous lines; bit order [0]up, [1]right, [2]down, [3]left, [4]SL, [5]SR, [6]hold, [7]game-reset.
- rd_en  in  1  CPU consumed the current code (read of r27); one pulse pops one entry.
- code  out  4  FIFO head; 0 when empty.
- valid  out  1  FIFO non-empty.
- overflow  out  1  sticky; a press was merged into an already-pending event.
- game_reset  out  1  debounced level of buttons[7].

## Operation
- Codes: up=1, right=2, down=3, left=4, SL=7, SR=8, hold=9. 0 = none.
- Each bit passes through a 2-flop synchronizer, then a debouncer. The debounced level flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
- A rising edge of a debounced bit 0–6 sets that button's pending bit. If the pending bit is already set, it stays set and overflow is set. Bit 7 never queues; it drives game_reset only.
- Arbiter: each cycle the FIFO is not full (or is popped that cycle), the highest-priority pending bit is written to the FIFO and cleared. Priority order is hold > SR > SL > left > down > right > up. At most one write per cycle.
- FIFO full with no pop: pending bits are held and no event is lost.
- rd_en while valid=0 is ignored. rd_en with a simultaneous write when full performs both; the count is unchanged.
- Counts wrap modulo FIFO_DEPTH via pointers; the count field is log2(FIFO_DEPTH)+1 bits.
- Reset (async, active-low): all synchronizers, debounced levels, counters, pending bits, FIFO pointers and overflow go to 0. Outputs are then code=0, valid=0, overflow=0, game_reset=0. Assertion mid-debounce or mid-repeat discards all state.

## Timing
- Raw edge to debounced change: 2 sync cycles + DEBOUNCE_CYCLES.
- Debounced rise at cycle N: pending set at N+1, FIFO written at N+2, valid=1 and code visible at N+2 if the FIFO was empty and no higher-priority event was pending.
- rd_en sampled at cycle N: next entry (or 0/valid=0) on code at N+1.
- Repeat counters (left, right, down only) start when the debounced level rises. The first repeat sets pending at REPEAT_DELAY cycles after the rise, then every REPEAT_RATE cycles while held. The counter clears on debounced fall.

## Configuration
- TETRIS_INPUT_REPEAT_EN defined: auto-repeat for left/right/down as above.
- Not defined: repeat counters are removed. Only debounced press edges generate events; REPEAT_DELAY and REPEAT_RATE are unused.

## Structure
- Shared package tetris_input_pkg holds the code localparams (CODE_NONE, CODE_UP … CODE_HOLD) and button index constants (BTN_UP … BTN_RST). The wrapper and the assembly-facing docs use the same values.
- One sub-module, tetris_debounce: a single-bit 2-flop synchronizer plus stable counter, instantiated 8×. The FIFO, arbiter and repeat counters are inline.

## Test plan
- DEBOUNCE_CYCLES=8: glitch buttons[3] high for 5 cycles → no event, valid stays 0. Hold 12 cycles → code=4, valid=1 at rise+2+8+2.
- Press up, left and hold in the same cycle, FIFO empty → successive codes 9, 4, 1, one per rd_en pulse. After the third pop, valid=0 and code=0.
- FIFO_DEPTH=4: six distinct presses with no rd_en → 4 entries queued, 2 pending held. Drain with 6 rd_en pulses → all 6 codes in priority/arrival order, overflow=0.
- Press right, release, then press right again before it leaves pending (FIFO full) → overflow=1 and sticky, one code 2 queued from the pair.
- With TETRIS_INPUT_REPEAT_EN, REPEAT_DELAY=20, REPEAT_RATE=5: hold down 40 cycles past the debounce → code 3 entries at rise, +20, +25, +30, +35. The SL button held the same way → exactly one code 7.
- Assert reset low mid-FIFO with 3 entries → valid, code, overflow and game_reset at 0 immediately. After release, no stale codes appear.
